// File: rtl/fde_if.sv
// Bus bundle between the fde_control sequencer and the instruction memory,
// register file and ALU.
interface fde_if #(
    parameter int PC_W = 8
);
    // Instruction-memory fetch handshake
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_valid;

    // Register-file addressing and write strobe
    logic [3:0]      rf_raddr1;
    logic [3:0]      rf_raddr2;
    logic [3:0]      rf_waddr;
    logic            rf_we;

    // ALU control and status
    logic [3:0]      alu_op;
    logic            alu_zero;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op,
        input  imem_rdata, imem_valid, alu_zero
    );

    // Memory / register file / ALU side
    modport slave (
        input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op,
        output imem_rdata, imem_valid, alu_zero
    );
endinterface

// File: rtl/fde_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit miniCPU.
// Owns the PC and the instruction register, and steps each instruction
// through FETCH -> DECODE -> EXEC (-> WB) before the next fetch.
module fde_control #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    fde_if.master           bus,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0]      OP_JMP  = 4'hC;
    localparam logic [3:0]      OP_BZ   = 4'hD;
    localparam logic [3:0]      OP_HALT = 4'hF;
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            illegal_q, illegal_d;
    logic [15:0]     retired_q, retired_d;

    logic            imem_req_d;
    logic            rf_we_d;
    logic [3:0]      alu_op_d;

    // IR field split; targets are resized to the PC width (zero-extend or truncate)
    logic [3:0]      opcode;
    logic            is_alu;
    logic            is_reserved;
    logic [PC_W-1:0] jmp_target;
    logic [PC_W-1:0] bz_target;

    assign opcode      = ir_q[15:12];
    assign is_alu      = (opcode >= 4'h1) && (opcode <= 4'h7);
    assign is_reserved = ((opcode >= 4'h8) && (opcode <= 4'hB)) || (opcode == 4'hE);
    assign jmp_target  = PC_W'(ir_q[11:0]);
    assign bz_target   = PC_W'(ir_q[7:0]);

    // State register: reset abandons any in-flight fetch immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            illegal_q <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, PC/IR update and per-state strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        imem_req_d = 1'b0;
        rf_we_d    = 1'b0;
        alu_op_d   = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_d = 1'b1;
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_op_d = opcode;
                if (is_alu) begin
                    state_d = S_WB;
                end else begin
                    // Non-ALU instructions retire here; a taken target replaces the +1 from FETCH
                    retired_d = retired_q + 16'd1;
                    if (opcode == OP_JMP) begin
                        pc_d = jmp_target;
                    end else if ((opcode == OP_BZ) && bus.alu_zero) begin
                        pc_d = bz_target;
                    end
                    if (is_reserved) begin
                        illegal_d = 1'b1;
                    end
                    state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
                end
            end
            S_WB: begin
                rf_we_d   = 1'b1;
                retired_d = retired_q + 16'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = imem_req_d;
    assign bus.imem_addr = pc_q;
    assign bus.rf_raddr1 = ir_q[11:8];
    assign bus.rf_raddr2 = ir_q[7:4];
    assign bus.rf_waddr  = ir_q[3:0];
    assign bus.rf_we     = rf_we_d;
    assign bus.alu_op    = alu_op_d;

    assign pc      = pc_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_fde_control.sv
// Self-checking bench for fde_control: directed scenarios followed by a
// random instruction stream checked against an instruction-level model.
module tb_fde_control;

    localparam int PC_W = 8;

    logic            clk;
    logic            reset;
    logic            run;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            illegal;
    logic [15:0]     retired;

    fde_if #(.PC_W(PC_W)) bus ();

    fde_control #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction-level reference state
    int m_pc  = 0;
    int m_ret = 0;
    int m_ill = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_pc",       32'(pc),           32'd0);
        check("rst_retired",  32'(retired),      32'd0);
        check("rst_illegal",  32'(illegal),      32'd0);
        check("rst_halted",   32'(halted),       32'd0);
        check("rst_rf_we",    32'(bus.rf_we),    32'd0);
        check("rst_alu_op",   32'(bus.alu_op),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        m_ill = 0;
    endtask

    // Pulse run for one cycle from IDLE or HALT; ends at a negedge in FETCH
    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("run_imem_req",  32'(bus.imem_req),  32'd1);
        check("run_imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        check("run_halted",    32'(halted),        32'd0);
    endtask

    // Execute one instruction; entered and left at a negedge
    task automatic do_instr(input logic [15:0] ins, input int wt, input logic z);
        int op;
        bit is_alu;
        bit is_res;
        int we_count;
        op       = int'(ins[15:12]);
        is_alu   = (op >= 1) && (op <= 7);
        is_res   = (op >= 8 && op <= 11) || (op == 14);
        we_count = 0;

        check("fetch_req",  32'(bus.imem_req),  32'd1);
        check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        for (int i = 0; i < wt; i++) begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 16'($urandom);
            @(negedge clk);
            check("wait_req",  32'(bus.imem_req),  32'd1);
            check("wait_addr", 32'(bus.imem_addr), 32'(m_pc));
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = ins;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'($urandom);

        // DECODE
        check("dec_raddr1", 32'(bus.rf_raddr1), 32'(ins[11:8]));
        check("dec_raddr2", 32'(bus.rf_raddr2), 32'(ins[7:4]));
        check("dec_req",    32'(bus.imem_req),  32'd0);
        check("dec_alu_op", 32'(bus.alu_op),    32'd0);
        we_count += int'(bus.rf_we);
        bus.alu_zero = z;
        @(negedge clk);

        // EXEC
        check("exec_alu_op", 32'(bus.alu_op),    32'(op));
        check("exec_raddr1", 32'(bus.rf_raddr1), 32'(ins[11:8]));
        check("exec_raddr2", 32'(bus.rf_raddr2), 32'(ins[7:4]));
        we_count += int'(bus.rf_we);

        m_pc = (m_pc + 1) % 256;
        if (op == 12) m_pc = int'(ins[11:0]) % 256;
        if (op == 13 && z) m_pc = int'(ins[7:0]);
        if (is_res) m_ill = 1;
        m_ret = (m_ret + 1) % 65536;

        if (is_alu) begin
            @(negedge clk);
            check("wb_rf_we",   32'(bus.rf_we),    32'd1);
            check("wb_waddr",   32'(bus.rf_waddr), 32'(ins[3:0]));
            check("wb_alu_op",  32'(bus.alu_op),   32'd0);
            we_count += int'(bus.rf_we);
        end
        @(negedge clk);
        we_count += int'(bus.rf_we);
        check("we_pulses", 32'(we_count),  is_alu ? 32'd1 : 32'd0);
        check("retired",   32'(retired),   32'(m_ret));
        check("illegal",   32'(illegal),   32'(m_ill));
        check("pc",        32'(pc),        32'(m_pc));
        if (op == 15) begin
            check("halt_halted", 32'(halted),       32'd1);
            check("halt_req",    32'(bus.imem_req), 32'd0);
        end else begin
            check("next_halted", 32'(halted),        32'd0);
            check("next_req",    32'(bus.imem_req),  32'd1);
            check("next_addr",   32'(bus.imem_addr), 32'(m_pc));
        end
        $display("instr %04h wait=%0d zero=%0d -> pc=%02h retired=%0d illegal=%0d",
                 ins, wt, z, pc, retired, illegal);
    endtask

    initial begin
        reset          = 1'b1;
        run            = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.alu_zero   = 1'b0;
        #1;
        check("por_pc",      32'(pc),           32'd0);
        check("por_req",     32'(bus.imem_req), 32'd0);
        check("por_retired", 32'(retired),      32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ALU sequence with zero wait, then a reserved opcode
        pulse_run();
        do_instr(16'h1234, 0, 1'b0);
        do_instr(16'hE777, 1, 1'b0);

        // Reset in the middle of a 3-cycle memory wait
        check("mid_req",  32'(bus.imem_req),  32'd1);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        apply_reset();
        // Stale completion while idle must be ignored
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'hC0A5;
        @(negedge clk);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        check("stale_req", 32'(bus.imem_req), 32'd0);
        check("stale_pc",  32'(pc),           32'd0);
        check("stale_ret", 32'(retired),      32'd0);

        // JMP from address 0
        pulse_run();
        do_instr(16'hC0A5, 0, 1'b0);

        // BZ taken at pc=5
        apply_reset();
        pulse_run();
        for (int i = 0; i < 5; i++) do_instr(16'h0000, 0, 1'b0);
        do_instr(16'hD012, 0, 1'b1);

        // BZ not taken at pc=5
        apply_reset();
        pulse_run();
        for (int i = 0; i < 5; i++) do_instr(16'h0000, int'($urandom_range(0, 2)), 1'b1);
        do_instr(16'hD012, 0, 1'b0);

        // HALT at 0xFF wraps pc to 0, then resume
        apply_reset();
        pulse_run();
        do_instr(16'hC0FF, 0, 1'b0);
        do_instr(16'hF000, 0, 1'b0);
        @(negedge clk);
        check("halt_hold", 32'(halted), 32'd1);
        pulse_run();

        // Random instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            do_instr(ins, int'($urandom_range(0, 3)), 1'($urandom));
            if (ins[15:12] == 4'hF) begin
                pulse_run();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Overall time bound
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fde_control.md
# fde_control

Multi-cycle fetch/decode/execute sequencer for the 16-bit miniCPU. Fetches instructions from instruction memory into an instruction register and splits them into fields: opcode [15:12], src1 [11:8], src2 [7:4], dst [3:0]. Steps each instruction through the register-file read, ALU and writeback phases. It sits between the instruction memory, the register file and the ALU, and is the only block that owns the PC.

## Interface
- PC_W, 8, PC / instruction-address width
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- run  in  1  start from IDLE or resume from HALT; ignored in other states
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  16  instruction word, valid when imem_valid=1
- imem_valid  in  1  fetch completion, may arrive any number of cycles after imem_req
- rf_raddr1  out  4  register-file read address 1 (IR src1)
- rf_raddr2  out  4  register-file read address 2 (IR src2)
- rf_waddr  out  4  register-file write address (IR dst)
- rf_we  out  1  register-file write strobe
- alu_op  out  4  ALU operation (IR opcode)
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- pc  out  PC_W  current PC
- halted  out  1  high while in HALT
- illegal  out  1  sticky: reserved opcode executed
- retired  out  16  retired-instruction counter

## Operation
- Opcode classes:
  - 0x0 NOP.
  - 0x1–0x7 ALU ops, which write dst.
  - 0xC JMP: pc <= {src1,src2,dst}[PC_W-1:0].
  - 0xD BZ: if alu_zero, pc <= {src2,dst} zero-extended or truncated to PC_W.
  - 0xF HALT.
  - 0x8–0xB and 0xE are reserved: executed as NOP and set illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: run=1 -> FETCH.
- FETCH:
  - imem_req=1 with imem_addr=pc, held stable until imem_valid.
  - On imem_valid (same cycle permitted): IR <= imem_rdata, pc <= pc+1 mod 2^PC_W, go to DECODE.
- DECODE: rf_raddr1/2 driven from IR; one cycle; go to EXEC.
- EXEC: alu_op=IR opcode; rf_raddr1/2 still driven; one cycle.
  - ALU ops -> WB.
  - JMP/BZ-taken load pc, then -> FETCH.
  - NOP/BZ-not-taken/reserved -> FETCH.
  - HALT -> HALT.
- WB: rf_we=1, rf_waddr=IR dst, for exactly one cycle; then -> FETCH.
- HALT:
  - halted=1; pc already points past the HALT word.
  - run=1 -> FETCH at that pc.
- Outside their active states:
  - rf_raddr1/2 and rf_waddr show IR fields (don't-care to consumers).
  - alu_op=0.
  - rf_we=0.
  - imem_req=0.
- retired increments by 1, wrapping at 2^16:
  - on leaving WB;
  - on leaving EXEC for any non-ALU opcode, HALT included.
- A jump or branch target overrides the +1 increment; there is no double update.

## Timing
- Reset values:
  - state IDLE; pc=RESET_PC; IR=0x0000.
  - imem_req=0, rf_we=0, alu_op=0, halted=0, illegal=0, retired=0.
- Reset is asynchronous: outputs reach reset values without a clock edge, and any in-flight fetch is abandoned. An imem_valid arriving after reset deasserts, while in IDLE, is ignored.
- Latency with zero-wait memory:
  - ALU instruction 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP/JMP/BZ/reserved 3 cycles.
  - HALT 3 cycles to halted=1.
- Each extra memory wait cycle adds one FETCH cycle.
- imem_valid outside FETCH is ignored.
- run is level-sampled. run held high through HALT re-enters FETCH on the next edge, so a HALT costs 4 cycles total.
- pc wraps from 2^PC_W−1 to 0 with no flag.
- illegal clears only on reset.

## Test plan
- Reset mid-fetch:
  - Stimulus: assert reset while imem_req=1 with a 3-cycle memory wait.
  - Required: imem_req, pc and state clear asynchronously; the stale imem_valid after release is ignored; retired=0.
- ALU sequence:
  - Stimulus: run; memory returns 0x1234 with zero wait.
  - Required: DECODE rf_raddr1=2, rf_raddr2=3; EXEC alu_op=1; WB rf_we=1 and rf_waddr=4 for one cycle; retired=1; pc=1 after 4 cycles.
- JMP:
  - Stimulus: memory at 0 holds 0xC0A5.
  - Required: next imem_addr=0xA5; no rf_we pulse; retired=1.
- BZ both ways:
  - Stimulus: 0xD012 at pc=5, first with alu_zero=1, then rerun with alu_zero=0.
  - Required: with alu_zero=1 the next fetch addr is 0x12; with alu_zero=0 it is 6.
- HALT and resume:
  - Stimulus: 0xF000 at pc=0xFF with PC_W=8; then pulse run.
  - Required: halted=1 and pc=0x00 (wrap); run pulse fetches address 0; halted drops.
- Reserved opcode:
  - Stimulus: execute 0xE777.
  - Required: illegal=1 stays set; no rf_we pulse; execution continues at pc+1.
